// File: rtl/encryption_top.sv
// Iterative AES-256 encryption core: one round per clock, key schedule expanded
// on the fly, free-running LOAD -> 13 x ROUND -> FINAL cycle of 15 clocks.

module encryption_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign y = SBOX[a];

endmodule

module encryption_top (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] plaintext,
  input  logic [255:0] key_i,
  output logic [127:0] ciphertext
);

  localparam logic [3:0] RND_LOAD  = 4'd0;
  localparam logic [3:0] RND_FINAL = 4'd14;

  logic [127:0] state;
  logic [127:0] ka;
  logic [127:0] kb;
  logic [7:0]   rcon;
  logic [3:0]   rnd;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  // SubBytes on the 16 state bytes; byte i = 4*column + row, MSB first.
  logic [15:0][7:0] sub_b;

  for (genvar i = 0; i < 16; i++) begin : g_state_sbox
    encryption_sbox u_sbox (
      .a (state[127-8*i -: 8]),
      .y (sub_b[i])
    );
  end

  logic [127:0] shifted;
  logic [127:0] mixed;

  // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    shifted = '0;
    mixed   = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        shifted[127-8*(4*c+r) -: 8] = sub_b[4*((c+r)%4)+r];
      end
    end
    for (int c = 0; c < 4; c++) begin
      mixed[127-32*c -: 32] = mix_column(shifted[127-32*c -: 32]);
    end
  end

  // Odd rounds generate words 8, 16, ... which take RotWord and Rcon.
  logic        rcon_gen;
  logic [31:0] last_w;
  logic [31:0] sbox_w;
  logic [31:0] sub_w;
  logic [31:0] temp;
  logic [31:0] n0, n1, n2, n3;

  assign rcon_gen = rnd[0];
  assign last_w   = kb[31:0];
  assign sbox_w   = rcon_gen ? {last_w[23:0], last_w[31:24]} : last_w;

  for (genvar j = 0; j < 4; j++) begin : g_key_sbox
    encryption_sbox u_sbox (
      .a (sbox_w[31-8*j -: 8]),
      .y (sub_w[31-8*j -: 8])
    );
  end

  assign temp = sub_w ^ (rcon_gen ? {rcon, 24'h0} : 32'h0);
  assign n0   = ka[127:96] ^ temp;
  assign n1   = ka[95:64]  ^ n0;
  assign n2   = ka[63:32]  ^ n1;
  assign n3   = ka[31:0]   ^ n2;

  // NOTE: sequential state is updated only with non-blocking assignments.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= '0;
      ka         <= '0;
      kb         <= '0;
      rcon       <= 8'h01;
      rnd        <= RND_LOAD;
      ciphertext <= '0;
    end else if (rnd == RND_LOAD) begin
      state <= plaintext ^ key_i[255:128];
      ka    <= key_i[255:128];
      kb    <= key_i[127:0];
      rcon  <= 8'h01;
      rnd   <= 4'd1;
    end else if (rnd >= RND_FINAL) begin
      ciphertext <= shifted ^ kb;
      rnd        <= RND_LOAD;
    end else begin
      state <= mixed ^ kb;
      ka    <= kb;
      kb    <= {n0, n1, n2, n3};
      if (rcon_gen) begin
        rcon <= xtime(rcon);
      end
      rnd <= rnd + 4'd1;
    end
  end

endmodule

// File: tb/tb_encryption_top.sv
// Directed-vector bench for encryption_top using FIPS-197 C.3, the all-zero
// AES-256 vector and the SP 800-38A F.1.5 ECB-AES256 vectors.

module tb_encryption_top;

  localparam logic [255:0] KEY_C3   = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] PT_C3    = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C3    = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] CT_ZERO  = 128'hdc95c078a2408989ad48a21492842087;
  localparam logic [255:0] KEY_SP   = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] PT_SP1   = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] CT_SP1   = 128'hf3eed1bdb5d2a03c064b5a7e3db181f8;
  localparam logic [127:0] PT_SP2   = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
  localparam logic [127:0] CT_SP2   = 128'h591ccb10d410ed26dc5ba74a31362870;
  localparam logic [127:0] PT_SP3   = 128'h30c81c46a35ce411e5fbc1191a0a52ef;
  localparam logic [127:0] CT_SP3   = 128'hb6ed21b99ca6f4f9f153e7b1beafed1d;
  localparam logic [127:0] PT_SP4   = 128'hf69f2445df4f9b17ad2b417be66c3710;
  localparam logic [127:0] CT_SP4   = 128'h23304b7a39f9f3ff067d8d8f9e24ecc7;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] plaintext;
  logic [255:0] key_i;
  logic [127:0] ciphertext;

  int n_vec = 0;
  int n_err = 0;

  encryption_top dut (
    .clk        (clk),
    .rst        (rst),
    .plaintext  (plaintext),
    .key_i      (key_i),
    .ciphertext (ciphertext)
  );

  always #5 clk = ~clk;

  // Advance by n rising edges; returns on the following falling edge.
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [127:0] expected);
    n_vec++;
    assert (ciphertext === expected)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, ciphertext, expected);
    end
  endtask

  // One rising edge with rst high, then released on the falling edge.
  task automatic pulse_reset;
    rst = 1'b1;
    step(1);
    rst = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    key_i     = KEY_C3;
    plaintext = PT_C3;

    // FIPS-197 C.3 with latency and hold checks.
    step(1);
    pulse_reset();
    check("reset_value", 128'h0);
    for (int k = 1; k <= 14; k++) begin
      step(1);
      check($sformatf("latency_edge%0d", k), 128'h0);
    end
    step(1);
    check("c3_edge15", CT_C3);
    step(14);
    check("c3_edge29_hold", CT_C3);
    step(1);
    check("c3_edge30", CT_C3);
    while ($time < 1000) step(1);
    check("c3_hold_1000ns", CT_C3);

    // All-zero key and plaintext.
    key_i     = '0;
    plaintext = '0;
    pulse_reset();
    step(15);
    check("zero_vector", CT_ZERO);

    // Inputs changed mid-encryption must not disturb the block in flight.
    key_i     = KEY_SP;
    plaintext = PT_SP1;
    pulse_reset();
    step(5);
    plaintext = PT_SP2;
    step(10);
    check("sp_blk1_edge15", CT_SP1);
    step(14);
    check("sp_blk1_hold", CT_SP1);
    step(1);
    check("sp_blk2_edge30", CT_SP2);
    plaintext = PT_SP3;
    step(15);
    check("sp_blk3_edge45", CT_SP3);
    plaintext = PT_SP4;
    step(3);
    key_i     = '0;
    plaintext = '0;
    step(12);
    check("sp_blk4_key_change", CT_SP4);
    step(15);
    check("zero_after_key_change", CT_ZERO);

    // Reset during round 7 discards the block and restarts the sequence.
    key_i     = KEY_C3;
    plaintext = PT_C3;
    step(7);
    check("hold_before_reset", CT_ZERO);
    pulse_reset();
    check("mid_reset_clear", 128'h0);
    step(14);
    check("post_reset_edge14", 128'h0);
    step(1);
    check("post_reset_edge15", CT_C3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
